// File: rtl/imem_loader.sv
// imem_loader: boot loader that fills instruction memory from a byte stream.
// It accepts a length-prefixed image over valid/ready:
//   N (16-bit, LSB first), 4*N data bytes (little-endian words), XOR checksum.
// Each assembled word is written as a single-cycle strobe. The core is held in
// reset until a load completes with a matching checksum.
// Ports:
//   clk, n_rst            clock, async active-low reset
//   start                 load request pulse (IDLE/DONE/ERROR only)
//   byte_in/byte_valid    stream input, byte_ready is the accept handshake
//   imem_we/addr/wdata    instruction-memory write port
//   core_n_rst            core reset, high only after a successful load
//   busy/done/err_code    status (err: 01 length, 10 checksum, 11 timeout)
//   words_loaded          words written by the current or last load
module imem_loader #(
  parameter int unsigned NUM_INSTR      = 64,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_n_rst,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err_code,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t      r_state;
  logic [7:0]  r_len_lo;
  logic [15:0] r_len;
  logic [23:0] r_word;      // lower three lanes; the fourth arrives with the write
  logic [7:0]  r_csum;
  logic [1:0]  r_byte_idx;
  logic [15:0] r_word_idx;
  logic [31:0] r_idle;

  state_t      w_next;
  logic [1:0]  w_err_next;
  logic        w_accept;
  logic        w_counting;
  logic        w_timeout;
  logic [15:0] w_len;
  logic        w_enter_len0;

  assign w_accept   = byte_valid & byte_ready;
  assign w_counting = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                      (r_state == S_DATA) || (r_state == S_CHECK);
  // Fires on the edge where the idle count would reach TIMEOUT_CYCLES-1.
  assign w_timeout  = w_counting && !w_accept &&
                      ((r_idle + 32'd1) >= (TIMEOUT_CYCLES - 32'd1));
  assign w_len      = {byte_in, r_len_lo};

  always_comb begin
    w_next     = r_state;
    w_err_next = 2'b00;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (start) w_next = S_LEN0;
      S_LEN0: begin
        if (w_timeout)     begin w_next = S_ERROR; w_err_next = 2'b11; end
        else if (w_accept) w_next = S_LEN1;
      end
      S_LEN1: begin
        if (w_timeout) begin
          w_next = S_ERROR; w_err_next = 2'b11;
        end else if (w_accept) begin
          if ({16'h0, w_len} > NUM_INSTR) begin
            w_next = S_ERROR; w_err_next = 2'b01;
          end else if (w_len == 16'h0) begin
            w_next = S_CHECK;
          end else begin
            w_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_timeout) begin
          w_next = S_ERROR; w_err_next = 2'b11;
        end else if (w_accept && (r_byte_idx == 2'd3)) begin
          w_next = S_WRITE;
        end
      end
      S_WRITE: w_next = ((r_word_idx + 16'd1) == r_len) ? S_CHECK : S_DATA;
      S_CHECK: begin
        if (w_timeout) begin
          w_next = S_ERROR; w_err_next = 2'b11;
        end else if (w_accept) begin
          if (byte_in == r_csum) w_next = S_DONE;
          else begin w_next = S_ERROR; w_err_next = 2'b10; end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter_len0 = (w_next == S_LEN0) && (r_state != S_LEN0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= S_IDLE;
      r_len_lo     <= '0;
      r_len        <= '0;
      r_word       <= '0;
      r_csum       <= '0;
      r_byte_idx   <= '0;
      r_word_idx   <= '0;
      r_idle       <= '0;
      byte_ready   <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_n_rst   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_code     <= '0;
      words_loaded <= '0;
    end else begin
      r_state    <= w_next;
      // Outputs are registered from the next state so they line up with it.
      byte_ready <= (w_next == S_LEN0) || (w_next == S_LEN1) ||
                    (w_next == S_DATA) || (w_next == S_CHECK);
      busy       <= (w_next == S_LEN0) || (w_next == S_LEN1) || (w_next == S_DATA) ||
                    (w_next == S_WRITE) || (w_next == S_CHECK);
      imem_we    <= (w_next == S_WRITE);
      done       <= (w_next == S_DONE);
      core_n_rst <= (w_next == S_DONE);

      if (w_accept || w_enter_len0) r_idle <= '0;
      else if (w_counting)          r_idle <= r_idle + 32'd1;

      if (w_enter_len0) begin
        err_code     <= '0;
        words_loaded <= '0;
      end else if ((w_next == S_ERROR) && (r_state != S_ERROR)) begin
        err_code <= w_err_next;
      end

      if ((r_state == S_LEN0) && w_accept) r_len_lo <= byte_in;

      if ((r_state == S_LEN1) && w_accept) begin
        r_len      <= w_len;
        r_csum     <= '0;
        r_word_idx <= '0;
        r_byte_idx <= '0;
      end

      if ((r_state == S_DATA) && w_accept && !w_timeout) begin
        r_csum     <= r_csum ^ byte_in;
        r_byte_idx <= r_byte_idx + 2'd1;
        case (r_byte_idx)
          2'd0:    r_word[7:0]   <= byte_in;
          2'd1:    r_word[15:8]  <= byte_in;
          2'd2:    r_word[23:16] <= byte_in;
          default: begin
            imem_addr  <= BASE_ADDR + {14'h0, r_word_idx, 2'b00};
            imem_wdata <= {byte_in, r_word};
          end
        endcase
      end

      if (r_state == S_WRITE) begin
        r_word_idx   <= r_word_idx + 16'd1;
        words_loaded <= words_loaded + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_n_rst;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;
  logic [15:0] words_loaded;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0]  img[$];
  logic [63:0] wrq[$];

  always #5 clk = ~clk;

  imem_loader #(
    .NUM_INSTR(64),
    .BASE_ADDR(32'h0),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_n_rst(core_n_rst),
    .busy(busy), .done(done), .err_code(err_code), .words_loaded(words_loaded)
  );

  // Capture every write strobe; stream must be stalled while writing.
  always @(negedge clk) begin
    if (n_rst && imem_we) begin
      wrq.push_back({imem_addr, imem_wdata});
      vectors++;
      if (byte_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL write_ready: byte_ready=%b required 0", byte_ready);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int mode);
    int  g;
    logic rdy;
    bit  ok;
    g = (mode == 1) ? 1 : ((mode == 2) ? int'($urandom_range(0, 3)) : 0);
    repeat (g) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_in    = b;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk); rdy = byte_ready;
      @(posedge clk); #1;
      if (rdy) ok = 1'b1;
    end
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL accept_wait: byte %h not accepted in 64 cycles", b);
    end
  endtask

  task automatic do_start(input string name);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (byte_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || core_n_rst !== 1'b0 ||
        err_code !== 2'b00 || words_loaded !== 16'h0) begin
      miscompares++;
      $display("FAIL %s_start: rdy=%b busy=%b done=%b crst=%b err=%b wl=%0d required 1 1 0 0 00 0",
               name, byte_ready, busy, done, core_n_rst, err_code, words_loaded);
    end
  endtask

  // Reference: parse img per the image format and predict the outcome.
  task automatic run_image(input string name, input int mode, input int start_at);
    int n, consumed, exp_err, exp_w;
    logic [7:0]  cs;
    logic [31:0] w;
    logic [63:0] exp_q[$];
    n = int'({img[1], img[0]});
    if (n > 64) begin
      consumed = 2; exp_err = 1; exp_w = 0;
    end else begin
      consumed = 2 + 4 * n + 1;
      cs = 8'h00;
      for (int i = 0; i < n; i++) begin
        w = {img[2+4*i+3], img[2+4*i+2], img[2+4*i+1], img[2+4*i]};
        exp_q.push_back({32'(4 * i), w});
        for (int k = 0; k < 4; k++) cs ^= img[2+4*i+k];
      end
      exp_err = (img[2+4*n] == cs) ? 0 : 2;
      exp_w   = n;
    end
    wrq.delete();
    do_start(name);
    for (int i = 0; i < consumed; i++) begin
      if (i == start_at) begin
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
      end
      send_byte(img[i], mode);
    end
    vectors++;
    if (wrq.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_nwrites: got %0d required %0d", name, wrq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wrq.size(); i++) begin
      vectors++;
      if (wrq[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s_write%0d: got %h/%h required %h/%h", name, i,
                 wrq[i][63:32], wrq[i][31:0], exp_q[i][63:32], exp_q[i][31:0]);
      end
    end
    vectors++;
    if (done !== (exp_err == 0) || core_n_rst !== (exp_err == 0)) begin
      miscompares++;
      $display("FAIL %s_done: done=%b core_n_rst=%b required %b", name, done, core_n_rst, exp_err == 0);
    end
    vectors++;
    if (err_code !== 2'(exp_err)) begin
      miscompares++;
      $display("FAIL %s_err: got %b required %b", name, err_code, 2'(exp_err));
    end
    vectors++;
    if (words_loaded !== 16'(exp_w)) begin
      miscompares++;
      $display("FAIL %s_words: got %0d required %0d", name, words_loaded, exp_w);
    end
    vectors++;
    if (busy !== 1'b0 || byte_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle: busy=%b byte_ready=%b required 0 0", name, busy, byte_ready);
    end
  endtask

  task automatic load_nominal(input logic [7:0] csum);
    img = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00, csum};
  endtask

  task automatic build_random(input int n, input bit corrupt);
    logic [7:0] b, cs;
    img.delete();
    img.push_back(8'(n)); img.push_back(8'(n >> 8));
    if (n <= 64) begin
      cs = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom); img.push_back(b); cs ^= b;
      end
      if (corrupt) cs ^= 8'($urandom_range(1, 255));
      img.push_back(cs);
    end else begin
      for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
    end
  endtask

  task automatic check_reset_values(input string name);
    vectors++;
    if (byte_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== 32'h0 || imem_wdata !== 32'h0 ||
        core_n_rst !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err_code !== 2'b00 ||
        words_loaded !== 16'h0) begin
      miscompares++;
      $display("FAIL %s: rdy=%b we=%b addr=%h wd=%h crst=%b busy=%b done=%b err=%b wl=%0d required all zero",
               name, byte_ready, imem_we, imem_addr, imem_wdata, core_n_rst, busy, done,
               err_code, words_loaded);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_state");
    n_rst = 1'b1;
    @(posedge clk); #1;
    check_reset_values("reset_idle");
  endtask

  task automatic test_nominal();
    load_nominal(8'h41); run_image("nominal", 0, -1);
  endtask

  task automatic test_bad_checksum();
    load_nominal(8'h40); run_image("badcsum", 0, -1);
  endtask

  task automatic test_len_too_big();
    img = '{8'h41, 8'h00}; run_image("toobig", 0, -1);
  endtask

  task automatic test_zero_len_backpressure();
    img = '{8'h00, 8'h00, 8'h00}; run_image("zerolen", 0, -1);
    load_nominal(8'h41);          run_image("backpressure", 1, -1);
  endtask

  task automatic test_ignored_start();
    load_nominal(8'h41); run_image("ignstart", 0, 5);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n;
      n = (it == 0) ? 64 : (it == 1) ? 65 : int'($urandom_range(0, 6));
      build_random(n, $urandom_range(0, 2) == 0);
      run_image($sformatf("rand%0d", it), 2, -1);
    end
  endtask

  task automatic test_timeout();
    int k;
    img = '{8'h02, 8'h00, 8'h93, 8'h00};
    wrq.delete();
    do_start("timeout");
    foreach (img[i]) send_byte(img[i], 0);
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      @(posedge clk); #1;
      if (err_code == 2'b11) k = i;
    end
    vectors++;
    if (k != 15) begin
      miscompares++;
      $display("FAIL timeout_cycles: err after %0d idle cycles required 15", k);
    end
    vectors++;
    if (wrq.size() != 0 || words_loaded !== 16'h0 || core_n_rst !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_state: writes=%0d wl=%0d crst=%b busy=%b required 0 0 0 0",
               wrq.size(), words_loaded, core_n_rst, busy);
    end
  endtask

  task automatic test_reset_restart();
    load_nominal(8'h41);
    wrq.delete();
    do_start("midload");
    for (int i = 0; i < 7; i++) send_byte(img[i], 0);
    n_rst = 1'b0;
    #1;
    check_reset_values("reset_midload");
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    run_image("restart", 0, -1);
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    vectors++;
    if (done !== 1'b0 || core_n_rst !== 1'b0 || words_loaded !== 16'h0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL relaunch: done=%b crst=%b wl=%0d busy=%b required 0 0 0 1",
               done, core_n_rst, words_loaded, busy);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_len_too_big();
    test_zero_len_backpressure();
    test_ignored_start();
    test_random();
    test_timeout();
    test_reset_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
